bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary decoder for the ALU front end. It accepts three BCD digits (hundreds, tens, units) from switch or keypad entry and converts them to an 8-bit binary operand. It uses an iterative reverse double-dabble (shift-right, subtract-3) datapath. It is the input-side counterpart of the binary-to-BCD/seven-segment display path. The handshake is start/busy/done, and it flags non-decimal digits and values above 255.

---
 rtl/bcd_to_bin_seq_pkg.sv | 22 ++
 rtl/bcd_to_bin_seq_if.sv | 28 ++
 rtl/bcd_sub3_mod.sv | 9 +
 rtl/bcd_to_bin_seq.sv | 135 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary decoder.
package bcd_to_bin_seq_pkg;

    localparam int unsigned NDIG_DEF  = 3;
    localparam int unsigned BIN_W_DEF = 8;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned DIGIT_MAX = 9;
    localparam int unsigned ITERS     = NDIG_DEF << 2;
    localparam int unsigned CNT_W     = $clog2(ITERS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True when a 4-bit code is not a decimal digit.
    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return d > DIGIT_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake and digit/result bus between requester and decoder.
interface bcd_to_bin_seq_if
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int unsigned BIN_W = BIN_W_DEF
);

    logic               start;
    logic [3:0]         bcd_hundreds;
    logic [3:0]         bcd_tens;
    logic [3:0]         bcd_units;
    logic               busy;
    logic               done;
    logic [BIN_W-1:0]   bin_out;
    logic               invalid;
    logic               overflow;

    modport master (
        output start, bcd_hundreds, bcd_tens, bcd_units,
        input  busy, done, bin_out, invalid, overflow
    );

    modport slave (
        input  start, bcd_hundreds, bcd_tens, bcd_units,
        output busy, done, bin_out, invalid, overflow
    );

endinterface

// File: rtl/bcd_sub3_mod.sv
// Reverse double-dabble digit correction: subtract 3 from a digit that is 8 or more.
module bcd_sub3_mod (
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    assign dout_c = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary decoder: one shift-right/subtract-3 step per cycle,
// saturating to all-ones with overflow flag, rejecting non-decimal digits.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int unsigned NDIG  = NDIG_DEF,
    parameter int unsigned BIN_W = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    bcd_to_bin_seq_if.slave  bus
);

    localparam int unsigned DW      = NDIG << 2;
    localparam int unsigned SW      = DW << 1;
    localparam int unsigned ITERS_L = NDIG << 2;
    localparam int unsigned CW      = $clog2(ITERS_L);
    localparam logic [CW-1:0] LAST  = CW'(ITERS_L - 1);
    localparam logic [DW-1:0] BIN_MAX = DW'((1 << BIN_W) - 1);

    state_e             state_q, state_d;
    logic [DW-1:0]      bcd_q, bcd_d;
    logic [DW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               invalid_q, invalid_d;
    logic               overflow_q, overflow_d;

    logic [SW-1:0]      shifted;
    logic [DW-1:0]      bcd_shift;
    logic [DW-1:0]      bcd_fix;
    logic [DW-1:0]      acc_shift;
    logic               any_bad;
    logic               sat;

    assign shifted   = {bcd_q, acc_q} >> 1;
    assign bcd_shift = shifted[SW-1:DW];
    assign acc_shift = shifted[DW-1:0];
    assign sat       = acc_shift > BIN_MAX;
    assign any_bad   = digit_bad(bus.bcd_hundreds) | digit_bad(bus.bcd_tens)
                     | digit_bad(bus.bcd_units);

    for (genvar g = 0; g < NDIG; g++) begin : g_sub3
        bcd_sub3_mod u_sub3 (
            .din    (bcd_shift[(g << 2) +: 4]),
            .dout_c (bcd_fix[(g << 2) +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bcd_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bin_q      <= '0;
            invalid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bin_q      <= bin_d;
            invalid_q  <= invalid_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        bin_d      = bin_q;
        invalid_d  = invalid_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (any_bad) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        bin_d      = '0;
                        invalid_d  = 1'b1;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                        bcd_d   = DW'({bus.bcd_hundreds, bus.bcd_tens, bus.bcd_units});
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_d  = bcd_fix;
                acc_d  = acc_shift;
                cnt_d  = cnt_q + CW'(1);
                busy_d = 1'b1;
                // Results come from this final step's value, not the stale register.
                if (cnt_q == LAST) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    invalid_d  = 1'b0;
                    overflow_d = sat;
                    bin_d      = sat ? '1 : BIN_W'(acc_shift);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bin_out  = bin_q;
    assign bus.invalid  = invalid_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: driver queues expected results, monitor checks on done.
module tb_bcd_to_bin_seq;
    import bcd_to_bin_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;

    bcd_to_bin_seq_if #(.BIN_W(8)) bus ();

    bcd_to_bin_seq #(.NDIG(3), .BIN_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bin;
        logic       inv;
        logic       ovf;
        int         cyc;
        int         busy_n;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         busy_run = 0;
    logic [7:0] prev_bin;
    logic       prev_inv;
    logic       prev_ovf;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: count busy cycles, compare every done against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (bus.busy) busy_run++;
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("bin_out",     int'(bus.bin_out),  int'(e.bin));
                    chk("invalid",     int'(bus.invalid),  int'(e.inv));
                    chk("overflow",    int'(bus.overflow), int'(e.ovf));
                    chk("done_cycle",  cyc,                e.cyc);
                    chk("busy_cycles", busy_run,           e.busy_n);
                end
                busy_run = 0;
            end
        end
    end

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},     int'(bus.busy),     0);
        chk({tag, "_done"},     int'(bus.done),     0);
        chk({tag, "_bin_out"},  int'(bus.bin_out),  0);
        chk({tag, "_invalid"},  int'(bus.invalid),  0);
        chk({tag, "_overflow"}, int'(bus.overflow), 0);
    endtask

    // One conversion; poke pulses start with other digits while the DUT is busy.
    task automatic issue(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                         input logic [7:0] eb, input logic ei, input logic eo,
                         input bit poke);
        @(posedge clk); #1;
        bus.bcd_hundreds = h;
        bus.bcd_tens     = t;
        bus.bcd_units    = u;
        bus.start        = 1'b1;
        q.push_back('{bin: eb, inv: ei, ovf: eo,
                      cyc: cyc + (ei ? 1 : 13), busy_n: (ei ? 0 : 12)});
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.bcd_hundreds = 4'hF;
        bus.bcd_tens     = 4'hF;
        bus.bcd_units    = 4'hF;
        if (!ei) begin
            @(negedge clk);
            chk("hold_bin_out",  int'(bus.bin_out),  int'(prev_bin));
            chk("hold_invalid",  int'(bus.invalid),  int'(prev_inv));
            chk("hold_overflow", int'(bus.overflow), int'(prev_ovf));
        end
        if (poke) begin
            repeat (4) @(posedge clk);
            #1;
            bus.bcd_hundreds = 4'd9;
            bus.bcd_tens     = 4'd9;
            bus.bcd_units    = 4'd9;
            bus.start        = 1'b1;
            @(posedge clk); #1;
            bus.start        = 1'b0;
        end
        prev_bin = eb;
        prev_inv = ei;
        prev_ovf = eo;
        wait_done(30);
    endtask

    initial begin
        int c;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.bcd_hundreds = 4'd0;
        bus.bcd_tens     = 4'd0;
        bus.bcd_units    = 4'd0;
        prev_bin         = 8'd0;
        prev_inv         = 1'b0;
        prev_ovf         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        issue(4'd2, 4'd5, 4'd5, 8'd255, 1'b0, 1'b0, 1'b0);
        issue(4'd0, 4'd0, 4'd0, 8'd0,   1'b0, 1'b0, 1'b0);
        issue(4'd1, 4'd2, 4'd8, 8'h80,  1'b0, 1'b0, 1'b0);
        issue(4'd2, 4'd5, 4'd6, 8'hFF,  1'b0, 1'b1, 1'b0);
        issue(4'd9, 4'd9, 4'd9, 8'hFF,  1'b0, 1'b1, 1'b0);
        issue(4'd1, 4'hA, 4'd3, 8'd0,   1'b1, 1'b0, 1'b0);
        issue(4'd0, 4'd4, 4'd2, 8'd42,  1'b0, 1'b0, 1'b0);
        issue(4'd0, 4'd5, 4'd0, 8'd50,  1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clk);

        // Abort a conversion with reset after five iterations; no done may follow.
        #1;
        bus.bcd_hundreds = 4'd1;
        bus.bcd_tens     = 4'd2;
        bus.bcd_units    = 4'd3;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start        = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        prev_bin = 8'd0;
        prev_inv = 1'b0;
        prev_ovf = 1'b0;
        issue(4'd0, 4'd9, 4'd9, 8'd99, 1'b0, 1'b0, 1'b0);

        // Start held high: back-to-back conversions every 14 cycles.
        @(posedge clk); #1;
        bus.bcd_hundreds = 4'd1;
        bus.bcd_tens     = 4'd0;
        bus.bcd_units    = 4'd0;
        bus.start        = 1'b1;
        c = cyc;
        for (int k = 0; k < 3; k++)
            q.push_back('{bin: 8'd100, inv: 1'b0, ovf: 1'b0,
                          cyc: c + 13 + 14 * k, busy_n: 12});
        for (int k = 0; k < 3; k++) wait_done(30);
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
